// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for NoC flit formatting.
//   Field offsets are bit positions counted down from the MSB of a flit.
//   The layout, MSB to LSB, is valid, head, tail, vc, payload.
//   payload_width() returns the number of payload bits per flit for a given
//   flit width and VC id width.
package noc_pkg;

    localparam int VALID_OFS = 0;
    localparam int HEAD_OFS  = 1;
    localparam int TAIL_OFS  = 2;
    localparam int HDR_BITS  = 3;   // valid + head + tail, VC field follows

    function automatic int payload_width(input int fw, input int v);
        return fw - HDR_BITS - v;
    endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// pkt_out_reg: a single-entry valid/ready pipeline register.
//   clk, rst_n : clock, synchronous active-low reset
//   in_data    : word to load
//   in_valid   : in_data is valid
//   in_ready   : the register can take a word this cycle
//   out_data   : registered word; all-zero while out_valid=0
//   out_valid  : the register holds a word
//   out_ready  : downstream takes the word this cycle
module pkt_out_reg #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    // An empty register, or one that drains this cycle, can load.
    assign in_ready = !valid_reg || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            // Drained with nothing behind it: clear the data as well so that
            // an idle output always reads as zero.
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;

endmodule

// File: rtl/packetizer_nflit.sv
// packetizer_nflit: builds an n-flit NoC packet from one user word.
//   clk, rst_n : clock, synchronous active-low reset
//   data_in    : payload word (WIDTH_IN)
//   valid_in   : data_in/dst_in/vc_in are valid
//   dst_in     : destination router address
//   vc_in      : virtual channel used for every flit
//   ready_out  : block accepts the input this cycle
//   data_out   : packet with all flits side by side, flit 0 (head) at the top
//   valid_out  : packet valid
//   ready_in   : downstream takes the packet this cycle
module packetizer_nflit
    import noc_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 12,
    parameter int WIDTH_OUT        = 36,
    parameter int NUM_FLITS        = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_IN-1:0]         data_in,
    input  logic                        valid_in,
    input  logic [ADDRESS_WIDTH-1:0]    dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    output logic                        ready_out,
    output logic [WIDTH_OUT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
);

    localparam int V  = VC_ADDRESS_WIDTH;
    localparam int FW = WIDTH_OUT / NUM_FLITS;
    localparam int PW = payload_width(FW, V);
    localparam int SW = NUM_FLITS * PW;            // payload stream width
    localparam int HW = ADDRESS_WIDTH + WIDTH_IN;  // meaningful stream bits

    if ((NUM_FLITS < 1) || (NUM_FLITS > 3) || (WIDTH_OUT % NUM_FLITS != 0) ||
        (HW > SW)) begin : g_param_err
        $fatal(1, "packetizer_nflit: illegal parameter combination");
    end

    // Payload stream: destination then data, left-justified, zero padded.
    logic [SW-1:0]        stream;
    logic [WIDTH_OUT-1:0] packet;

    assign stream = SW'({dst_in, data_in}) << (SW - HW);

    for (genvar gi = 0; gi < NUM_FLITS; gi++) begin : g_flit
        localparam int MSB = WIDTH_OUT - 1 - gi * FW;
        assign packet[MSB - VALID_OFS]         = 1'b1;
        assign packet[MSB - HEAD_OFS]          = 1'(gi == 0);
        assign packet[MSB - TAIL_OFS]          = 1'(gi == NUM_FLITS - 1);
        assign packet[MSB - HDR_BITS -: V]     = vc_in;
        assign packet[MSB - HDR_BITS - V -: PW] = stream[SW - 1 - gi * PW -: PW];
    end

    pkt_out_reg #(
        .W(WIDTH_OUT)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (packet),
        .in_valid (valid_in),
        .in_ready (ready_out),
        .out_data (data_out),
        .out_valid(valid_out),
        .out_ready(ready_in)
    );

endmodule

// File: tb/tb_packetizer_nflit.sv
// tb_packetizer_nflit: drives three packetizers (1, 2 and 3 flits, 36-bit
// output) from shared inputs and checks them against a field-level packet
// model plus a queue of packets expected at the output.
module tb_packetizer_nflit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  dst_in = '0;
    logic [0:0]  vc_in = '0;
    logic        ready_in = 1'b0;

    logic [35:0] dout [3];
    logic        vout [3];
    logic        rout [3];

    int compared = 0;
    int mismatched = 0;

    // Packets accepted but not yet taken, one queue per flit count.
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] q2[$];

    always #5 clk = ~clk;

    packetizer_nflit #(.NUM_FLITS(1), .WIDTH_OUT(36)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .dst_in(dst_in), .vc_in(vc_in), .ready_out(rout[0]), .data_out(dout[0]),
        .valid_out(vout[0]), .ready_in(ready_in));
    packetizer_nflit #(.NUM_FLITS(2), .WIDTH_OUT(36)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .dst_in(dst_in), .vc_in(vc_in), .ready_out(rout[1]), .data_out(dout[1]),
        .valid_out(vout[1]), .ready_in(ready_in));
    packetizer_nflit #(.NUM_FLITS(3), .WIDTH_OUT(36)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .dst_in(dst_in), .vc_in(vc_in), .ready_out(rout[2]), .data_out(dout[2]),
        .valid_out(vout[2]), .ready_in(ready_in));

    // Packet as the field rules describe it: header bits per flit, then the
    // {dst, data, zeros} stream cut into equal MSB-first payload chunks.
    function automatic logic [35:0] model_pkt(input int nf, input logic [11:0] d,
                                               input logic [3:0] a, input logic c);
        int          fw;
        int          pw;
        logic [63:0] s;
        logic [63:0] chunk;
        logic [63:0] flit;
        logic [35:0] p;
        fw = 36 / nf;
        pw = fw - 4;
        s  = {48'b0, a, d} << (nf * pw - 16);
        p  = '0;
        for (int i = 0; i < nf; i++) begin
            chunk = (s >> ((nf - 1 - i) * pw)) & ((64'd1 << pw) - 64'd1);
            flit  = ({60'b0, 1'b1, 1'(i == 0), 1'(i == nf - 1), c} << pw) | chunk;
            p     = p | 36'(flit << ((nf - 1 - i) * fw));
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_out_nf1", 36'(vout[0]), 36'(q0.size() != 0));
        chk("valid_out_nf2", 36'(vout[1]), 36'(q1.size() != 0));
        chk("valid_out_nf3", 36'(vout[2]), 36'(q2.size() != 0));
        chk("data_out_nf1", dout[0], (q0.size() != 0) ? q0[0] : 36'd0);
        chk("data_out_nf2", dout[1], (q1.size() != 0) ? q1[0] : 36'd0);
        chk("data_out_nf3", dout[2], (q2.size() != 0) ? q2[0] : 36'd0);
    endtask

    // One clock cycle: apply inputs at the falling edge, check ready_out,
    // update the expected queues at the rising edge, check outputs after it.
    task automatic step(input logic v, input logic [11:0] d, input logic [3:0] a,
                        input logic c, input logic r, input logic rn);
        logic exp_rdy;
        logic in_x;
        logic out_x;
        valid_in = v;
        data_in  = d;
        dst_in   = a;
        vc_in    = c;
        ready_in = r;
        rst_n    = rn;
        #1;
        exp_rdy = (q0.size() == 0) || r;
        chk("ready_out_nf1", 36'(rout[0]), 36'(exp_rdy));
        chk("ready_out_nf2", 36'(rout[1]), 36'(exp_rdy));
        chk("ready_out_nf3", 36'(rout[2]), 36'(exp_rdy));
        in_x  = v && exp_rdy;
        out_x = (q0.size() != 0) && r;
        @(posedge clk);
        if (!rn) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (out_x) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                void'(q2.pop_front());
            end
            if (in_x) begin
                q0.push_back(model_pkt(1, d, a, c));
                q1.push_back(model_pkt(2, d, a, c));
                q2.push_back(model_pkt(3, d, a, c));
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        chk("reset_ready_out", 36'(rout[0]), 36'd1);

        // Known-answer packets
        step(1'b1, 12'hABC, 4'h5, 1'b1, 1'b1, 1'b1);
        chk("kat_nf1", dout[0], 36'hF_5ABC_0000);
        chk("kat_nf3", dout[2], 36'hD5A_9BC_B00);
        step(1'b1, 12'hABC, 4'h5, 1'b0, 1'b1, 1'b1);
        chk("kat_nf2", dout[1], 36'hC5ABE8000);

        // Backpressure: output held for 5 cycles while new inputs wait
        for (int i = 0; i < 5; i++)
            step(1'b1, 12'h123 + 12'(i), 4'h3, 1'b1, 1'b0, 1'b1);
        chk("bp_hold_nf2", dout[1], 36'hC5ABE8000);
        step(1'b1, 12'h456, 4'h9, 1'b1, 1'b1, 1'b1);
        chk("bp_next_nf1", dout[0], model_pkt(1, 12'h456, 4'h9, 1'b1));

        // Streaming: 10 back-to-back packets
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 12'(i + 1), 4'(i), 1'(i), 1'b1, 1'b1);
            chk("stream_nf3", dout[2], model_pkt(3, 12'(i + 1), 4'(i), 1'(i)));
        end
        step(1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b1);

        // Reset during a stall
        step(1'b1, 12'h777, 4'hE, 1'b0, 1'b0, 1'b1);
        step(1'b1, 12'h888, 4'hD, 1'b1, 1'b0, 1'b1);
        step(1'b1, 12'h999, 4'hC, 1'b1, 1'b0, 1'b0);
        chk("stall_reset_nf1", dout[0], 36'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 12'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
